// File: rtl/iis_pkg.sv
// Shared I2S definitions: frame geometry and FSM encoding.
// Used by both the transmitter and the receiver.
package iis_pkg;

  localparam int DATA_BIT  = 24;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_DIV  = 32;
  localparam int FRAME_DIV = 2048;

  localparam int TICK_W = $clog2(FRAME_DIV);
  localparam int BCLK_W = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    TX_LEFT    = 2'd1,
    TX_RIGHT   = 2'd2
  } iis_state_e;

endpackage

// File: rtl/iis_clk_gen.sv
// I2S timing generator: one free-running tick counter that yields
// bclk, lrclk, edge strobes and the slot about to start.
module iis_clk_gen
  import iis_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              bclk,
  output logic              lrclk,
  output logic              bclk_fall,
  output logic              frame_start,
  output logic              half_start,
  output logic [SLOT_W-1:0] slot_nxt,
  output logic              half_nxt
);

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;

  // counter simply wraps at the frame length
  always_comb begin
    tick_d = tick_q + 1'b1;
  end

  // tick register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign bclk        = tick_q[BCLK_W-1];
  assign lrclk       = tick_q[TICK_W-1];
  assign bclk_fall   = &tick_q[BCLK_W-1:0];
  assign frame_start = &tick_q;
  assign half_start  = (&tick_q[TICK_W-2:0]) & ~tick_q[TICK_W-1];
  assign slot_nxt    = tick_d[BCLK_W +: SLOT_W];
  assign half_nxt    = tick_d[TICK_W-1];

endmodule

// File: rtl/iis_write_logic.sv
// I2S transmitter: one-deep sample holding register, per-frame
// shift words and serial data aligned to the falling bclk edge.
module iis_write_logic #(
  parameter int DATA_BIT  = iis_pkg::DATA_BIT,
  parameter int SLOT_BITS = iis_pkg::SLOT_BITS
) (
  input  logic                clk_100m,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] ldata_i,
  input  logic [DATA_BIT-1:0] rdata_i,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata_o,
  output logic                underrun
);
  import iis_pkg::*;

  localparam int SW = $clog2(SLOT_BITS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(DATA_BIT);

  logic bclk_fall;
  logic frame_start;
  logic half_start;
  logic half_nxt;
  logic [SW-1:0] slot_nxt;

  iis_state_e state_q, state_d;

  logic hold_full_q, hold_full_d;
  logic [DATA_BIT-1:0] hold_l_q, hold_l_d;
  logic [DATA_BIT-1:0] hold_r_q, hold_r_d;
  logic [DATA_BIT-1:0] tx_l_q, tx_l_d;
  logic [DATA_BIT-1:0] tx_r_q, tx_r_d;
  logic sdata_q, sdata_d;
  logic underrun_q, underrun_d;
  logic tx_active;
  logic accept;
  logic [DATA_BIT-1:0] word;
  logic [DATA_BIT-1:0] shifted;

  iis_clk_gen u_clk_gen (
    .clk         (clk_100m),
    .rst         (rst),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start),
    .half_start  (half_start),
    .slot_nxt    (slot_nxt),
    .half_nxt    (half_nxt)
  );

  assign sample_ready = ~hold_full_q;
  assign accept       = sample_valid & ~hold_full_q;

  // frame load empties the holder; a same-cycle accept refills it
  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    if (frame_start) begin
      tx_l_d      = hold_full_q ? hold_l_q : '0;
      tx_r_d      = hold_full_q ? hold_r_q : '0;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_l_d    = ldata_i;
      hold_r_d    = rdata_i;
      hold_full_d = 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FRAME: if (frame_start) state_d = TX_LEFT;
      TX_LEFT:    if (half_start)  state_d = TX_RIGHT;
      TX_RIGHT:   if (frame_start) state_d = TX_LEFT;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // state-derived outputs; first boundary after reset is not an underrun
  always_comb begin
    tx_active  = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      WAIT_FRAME: tx_active = 1'b0;
      TX_LEFT:    tx_active = 1'b1;
      TX_RIGHT: begin
        tx_active  = 1'b1;
        underrun_d = frame_start & ~hold_full_q;
      end
      default:    tx_active = 1'b0;
    endcase
  end

  // slot 0 is the one-bit delay, then MSB first, then zero padding
  always_comb begin
    word    = half_nxt ? tx_r_q : tx_l_q;
    shifted = word << (slot_nxt - SW'(1));
    sdata_d = sdata_q;
    if (bclk_fall) begin
      sdata_d = tx_active && (slot_nxt != '0) && (slot_nxt <= LAST_SLOT)
                ? shifted[DATA_BIT-1] : 1'b0;
    end
  end

  // state, holder, shift words and registered outputs
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_FRAME;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sdata_o  = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_iis_write_logic.sv
// Directed bench for iis_write_logic with an I2S receiver model
// that decodes sdata_o on rising bclk.
module tb_iis_write_logic;

  logic        clk_100m = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] ldata_i = '0;
  logic [23:0] rdata_i = '0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata_o;
  logic        underrun;

  always #5 clk_100m = ~clk_100m;

  iis_write_logic dut (
    .clk_100m     (clk_100m),
    .rst          (rst),
    .ldata_i      (ldata_i),
    .rdata_i      (rdata_i),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata_o      (sdata_o),
    .underrun     (underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always @(posedge clk_100m or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic        mon_en = 1'b0;
  logic        sd_prev = 1'b0;
  int          bclk_err, lr_err, edge_err, pad_err, ones;
  logic [23:0] wl [8];
  logic [23:0] wr [8];
  int          ur_q [$];

  // receiver model and timing tracker
  initial begin
    int t, f, s;
    forever begin
      @(negedge clk_100m);
      if (mon_en && !rst) begin
        t = cyc % 2048;
        f = cyc / 2048;
        s = (t / 32) % 32;
        if (bclk !== t[4]) bclk_err++;
        if (lrclk !== t[10]) lr_err++;
        if ((t % 32) != 0 && sdata_o !== sd_prev) edge_err++;
        sd_prev = sdata_o;
        if (sdata_o === 1'b1) ones++;
        if (underrun === 1'b1) ur_q.push_back(cyc);
        if ((t % 32) == 16 && f < 8) begin
          if (s >= 1 && s <= 24) begin
            if (t[10]) wr[f][24-s] = sdata_o;
            else       wl[f][24-s] = sdata_o;
          end else if (sdata_o !== 1'b0) begin
            pad_err++;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ur_at(input int i);
    if (ur_q.size() > i) return ur_q[i];
    return -1;
  endfunction

  task automatic do_reset(input bit chk);
    mon_en = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk_100m);
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_bclk", 32'(bclk), 0);
      check("rst_lrclk", 32'(lrclk), 0);
      check("rst_sdata", 32'(sdata_o), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_ready", 32'(sample_ready), 1);
    end
    repeat (3) @(posedge clk_100m);
    bclk_err = 0; lr_err = 0; edge_err = 0;
    pad_err = 0; ones = 0;
    for (int i = 0; i < 8; i++) begin
      wl[i] = '0;
      wr[i] = '0;
    end
    ur_q.delete();
    sd_prev = 1'b0;
    #2;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_100m);
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    sample_valid = 1'b1;
    ldata_i = l;
    rdata_i = r;
    @(negedge clk_100m);
    sample_valid = 1'b0;
  endtask

  initial begin
    int rc;

    // idle run, no samples
    #2;
    do_reset(1'b1);
    wait_cyc(6200);
    check("idle_bclk_err", 32'(bclk_err), 0);
    check("idle_lrclk_err", 32'(lr_err), 0);
    check("idle_edge_err", 32'(edge_err), 0);
    check("idle_ones", 32'(ones), 0);
    check("idle_ur_cnt", 32'(ur_q.size()), 2);
    check("idle_ur0", 32'(ur_at(0)), 4096);
    check("idle_ur1", 32'(ur_at(1)), 6144);

    // one pair before the first boundary
    do_reset(1'b0);
    wait_cyc(10);
    offer(24'hA5A5A5, 24'h5A5A5A);
    check("a5_ready_low", 32'(sample_ready), 0);
    wait_cyc(2049);
    check("a5_ready_back", 32'(sample_ready), 1);
    wait_cyc(4200);
    check("a5_f0_left", 32'(wl[0]), 0);
    check("a5_left", 32'(wl[1]), 32'hA5A5A5);
    check("a5_right", 32'(wr[1]), 32'h5A5A5A);
    check("a5_pad_err", 32'(pad_err), 0);
    check("a5_edge_err", 32'(edge_err), 0);
    check("a5_ur0", 32'(ur_at(0)), 4096);

    // back-to-back pairs, second stalls on full holder
    do_reset(1'b0);
    wait_cyc(10);
    sample_valid = 1'b1;
    ldata_i = 24'h800000;
    rdata_i = 24'h7FFFFF;
    @(negedge clk_100m);
    ldata_i = 24'h000001;
    rdata_i = 24'hFFFFFF;
    rc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (sample_ready) begin
        rc = cyc;
        break;
      end
      @(negedge clk_100m);
    end
    @(negedge clk_100m);
    sample_valid = 1'b0;
    check("b2b_ready_cyc", 32'(rc), 2048);
    check("b2b_held", 32'(sample_ready), 0);
    wait_cyc(6200);
    check("b2b_f1_left", 32'(wl[1]), 32'h800000);
    check("b2b_f1_right", 32'(wr[1]), 32'h7FFFFF);
    check("b2b_f2_left", 32'(wl[2]), 32'h000001);
    check("b2b_f2_right", 32'(wr[2]), 32'hFFFFFF);
    check("b2b_ur0", 32'(ur_at(0)), 6144);

    // valid exactly on a boundary cycle with holder empty
    do_reset(1'b0);
    wait_cyc(4095);
    sample_valid = 1'b1;
    ldata_i = 24'h3C3C3C;
    rdata_i = 24'hC3C3C3;
    @(negedge clk_100m);
    sample_valid = 1'b0;
    check("bnd_stored", 32'(sample_ready), 0);
    wait_cyc(8250);
    check("bnd_f2_left", 32'(wl[2]), 0);
    check("bnd_f2_right", 32'(wr[2]), 0);
    check("bnd_f3_left", 32'(wl[3]), 32'h3C3C3C);
    check("bnd_f3_right", 32'(wr[3]), 32'hC3C3C3);
    check("bnd_ur_cnt", 32'(ur_q.size()), 2);
    check("bnd_ur0", 32'(ur_at(0)), 4096);
    check("bnd_ur1", 32'(ur_at(1)), 8192);

    // reset mid right word with a pair held
    do_reset(1'b0);
    wait_cyc(10);
    offer(24'h123456, 24'hABCDEF);
    wait_cyc(2100);
    offer(24'h0F0F0F, 24'hF0F0F0);
    wait_cyc(3548);
    check("mid_lrclk_pre", 32'(lrclk), 1);
    check("mid_bclk_pre", 32'(bclk), 1);
    check("mid_held_pre", 32'(sample_ready), 0);
    check("mid_f1_left", 32'(wl[1]), 32'h123456);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_bclk", 32'(bclk), 0);
    check("mid_lrclk", 32'(lrclk), 0);
    check("mid_sdata", 32'(sdata_o), 0);
    check("mid_underrun", 32'(underrun), 0);
    check("mid_ready", 32'(sample_ready), 1);
    do_reset(1'b0);
    wait_cyc(4150);
    check("mid_lost_left", 32'(wl[1]), 0);
    check("mid_lost_right", 32'(wr[1]), 0);
    check("mid_ur0", 32'(ur_at(0)), 4096);

    // loopback decode of a full pair
    do_reset(1'b0);
    wait_cyc(10);
    offer(24'h123456, 24'hABCDEF);
    wait_cyc(4100);
    check("loop_left", 32'(wl[1]), 32'h123456);
    check("loop_right", 32'(wr[1]), 32'hABCDEF);
    check("loop_bclk_err", 32'(bclk_err), 0);
    check("loop_lrclk_err", 32'(lr_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iis_write_logic.md
IIS_WRITE_LOGIC -- requirements
Module: iis_write_logic

Interface
REQ-001 SHALL have parameter DATA_BIT, default 24, meaning sample width per channel.
REQ-002 SHALL have parameter SLOT_BITS, default 32, meaning bclk periods per channel half-frame.
REQ-003 clk_100m  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ldata_i  input  DATA_BIT  left sample, two's complement.
REQ-006 rdata_i  input  DATA_BIT  right sample, two's complement.
REQ-007 sample_valid  input  1  ldata_i/rdata_i pair offered.
REQ-008 sample_ready  output  1  holding register empty, pair accepted when valid and ready.
REQ-009 bclk  output  1  serial bit clock, clk_100m/32.
REQ-010 lrclk  output  1  word select, clk_100m/2048; low = left, high = right.
REQ-011 sdata_o  output  1  I2S serial data, MSB first.
REQ-012 underrun  output  1  one-cycle pulse when a frame starts with no pair held.

Function
REQ-013 SHALL use one 11-bit free-running counter (tick); bclk = tick[4], lrclk = tick[10], slot = tick[9:5].
REQ-014 bclk, lrclk and sdata_o SHALL all be registered outputs; sdata_o SHALL change only on the clk_100m edge where bclk falls (tick[4:0] 31->0).
REQ-015 Per half-frame: slot 0 -> 0 (I2S one-bit delay); slots 1..24 -> sample bits 23..0; slots 25..31 -> 0.
REQ-016 Left channel SHALL be sent in the lrclk-low half, right in the lrclk-high half of the same frame.
REQ-017 Frame boundary SHALL be the tick 2047->0 edge; at that edge tx_l/tx_r load from the holding register if full, else load zero.
REQ-018 FSM states: WAIT_FRAME, TX_LEFT, TX_RIGHT; reset -> WAIT_FRAME; WAIT_FRAME -> TX_LEFT at first frame boundary; TX_LEFT -> TX_RIGHT at tick 1023->1024; TX_RIGHT -> TX_LEFT at frame boundary.
REQ-019 underrun SHALL pulse for exactly one cycle at a frame boundary in TX_RIGHT with the holding register empty; it SHALL NOT pulse on the WAIT_FRAME -> TX_LEFT transition.
REQ-020 sample_ready = holding register empty; combinational from that flag only, no dependence on sample_valid.
REQ-021 Simultaneous frame load and accept (holding empty, valid high at boundary): frame loads zero (underrun rules apply), accepted pair is stored for the next frame.
REQ-022 Holding register SHALL clear to empty in the same cycle its contents are loaded into tx_l/tx_r.
REQ-023 Held pair SHALL remain unchanged while sample_ready is low; sample_valid with ready low SHALL have no effect.

Reset
REQ-024 On rst: tick=0, bclk=0, lrclk=0, sdata_o=0, underrun=0, holding empty (sample_ready=1), tx_l=tx_r=0, state WAIT_FRAME.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; the partially sent word is discarded and never resumed.

Structure
REQ-026 Shared package iis_pkg SHALL hold DATA_BIT, SLOT_BITS, BCLK_DIV=32, FRAME_DIV=2048 and the FSM state encoding, reused by the I2S receiver.
REQ-027 Sub-module iis_clk_gen SHALL own the tick counter and emit bclk, lrclk, bclk_fall and frame_start strobes; it is reusable by the receiver.

Verification
REQ-028 Reset release, no samples -> bclk period 32 clk, lrclk period 2048 clk, sdata_o=0 throughout, underrun pulses first at tick wrap #2 then every 2048 clk.
REQ-029 Offer 0xA5A5A5/0x5A5A5A before first boundary -> sample_ready drops after accept; left slots 1..24 sampled on bclk rise = 0xA5A5A5, right = 0x5A5A5A; slots 0, 25..31 = 0.
REQ-030 Hold valid high with pairs 0x800000/0x7FFFFF then 0x000001/0xFFFFFF -> second pair stalled until next boundary, transmitted exactly one frame later, no underrun.
REQ-031 Valid asserted exactly on the boundary cycle with holding empty -> underrun pulse, zero frame, pair sent in following frame.
REQ-032 Assert rst at tick 1500 mid-right-word -> all outputs at reset values next cycle, sample_ready=1, held pair lost.
REQ-033 Loopback sdata_o/bclk/lrclk into the team's I2S receiver, send 0x123456/0xABCDEF -> receiver left/right outputs equal 0x123456/0xABCDEF within two frames.
